// File: rtl/fifo_serializer_if.sv
// fifo_serializer_if
// Bundles the two handshakes of the FIFO drain stage into one interface:
//   - FIFO read port: fifo_empty, fifo_rd_data, fifo_rd_en
//   - serial valid/ready port: ser_ready, ser_valid, ser_data, ser_first, ser_last
// Modports:
//   master : the serializer (pops the FIFO, drives the serial stream)
//   slave  : the environment (FIFO and downstream sink)
// Parameter DATA_WIDTH must match the serializer's DATA_WIDTH.

interface fifo_serializer_if #(
    parameter int DATA_WIDTH = 4
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  fifo_rd_en;
    logic                  ser_ready;
    logic                  ser_valid;
    logic                  ser_data;
    logic                  ser_first;
    logic                  ser_last;

    modport master (
        input  fifo_empty,
        input  fifo_rd_data,
        input  ser_ready,
        output fifo_rd_en,
        output ser_valid,
        output ser_data,
        output ser_first,
        output ser_last
    );

    modport slave (
        output fifo_empty,
        output fifo_rd_data,
        output ser_ready,
        input  fifo_rd_en,
        input  ser_valid,
        input  ser_data,
        input  ser_first,
        input  ser_last
    );
endinterface

// File: rtl/fifo_serializer.sv
// fifo_serializer
// Drain stage behind a FIFO: pops one DATA_WIDTH-bit word at a time and shifts it
// out one bit per accepted cycle on a valid/ready serial port. At most one FIFO
// read is outstanding; completed frames are counted in words_sent.
//
// Ports:
//   clk        in   single clock, rising edge
//   reset      in   asynchronous, active-high, clears all state
//   bus        if   fifo_serializer_if.master (FIFO read port + serial port)
//   busy       out  FSM is not idle
//   words_sent out  completed frames, wraps modulo 2^CNT_WIDTH
//
// Parameters: DATA_WIDTH, RD_LATENCY (0 or 1), MSB_FIRST, CNT_WIDTH.
// Optional feature macro: FIFO_SER_PARITY_EN -- when defined, every frame carries
// an extra trailing even-parity bit (^word) and ser_last marks that bit.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | nothing to send; pops the FIFO as soon as it is not empty
// WAIT   | pop issued, read data arrives this cycle (RD_LATENCY=1 only)
// SHIFT  | presenting bits of the loaded word on the serial port

module fifo_serializer #(
    parameter int DATA_WIDTH = 4,
    parameter int RD_LATENCY = 1,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    fifo_serializer_if.master    bus,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] words_sent
);

`ifdef FIFO_SER_PARITY_EN
    localparam int FRAME_LEN = DATA_WIDTH + 1;
`else
    localparam int FRAME_LEN = DATA_WIDTH;
`endif
    localparam int BC_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [BC_W-1:0] LAST_IDX = BC_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [DATA_WIDTH-1:0] shreg;
    logic [BC_W-1:0]       bit_cnt;
`ifdef FIFO_SER_PARITY_EN
    logic                  par_bit;
`endif
    logic                  xfer;
    logic                  is_last;
    logic                  load;
    logic                  rd_req;
    logic                  data_bit;

    assign xfer    = (state == ST_SHIFT) && bus.ser_ready;
    assign is_last = (bit_cnt == LAST_IDX);

    always_comb begin
        state_nxt = state;
        rd_req    = 1'b0;
        load      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!bus.fifo_empty) begin
                    rd_req = 1'b1;
                    if (RD_LATENCY == 0) begin
                        load      = 1'b1;
                        state_nxt = ST_SHIFT;
                    end else begin
                        state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                load      = 1'b1;
                state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                // The next pop is only issued on the final accepted bit, so the
                // shift register is never overwritten while still in use.
                if (xfer && is_last) begin
                    if (!bus.fifo_empty) begin
                        rd_req = 1'b1;
                        if (RD_LATENCY == 0) begin
                            load = 1'b1;
                        end else begin
                            state_nxt = ST_WAIT;
                        end
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        data_bit = MSB_FIRST ? shreg[DATA_WIDTH-1] : shreg[0];
`ifdef FIFO_SER_PARITY_EN
        if (bit_cnt == BC_W'(DATA_WIDTH)) begin
            data_bit = par_bit;
        end
`endif
    end

    // The IDLE pop is combinational on fifo_empty, so it must also be masked
    // while reset is held.
    assign bus.fifo_rd_en = rd_req & ~reset;
    assign bus.ser_valid  = (state == ST_SHIFT);
    assign bus.ser_data   = (state == ST_SHIFT) & data_bit;
    assign bus.ser_first  = (state == ST_SHIFT) && (bit_cnt == '0);
    assign bus.ser_last   = (state == ST_SHIFT) && is_last;
    assign busy           = (state != ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            words_sent <= '0;
`ifdef FIFO_SER_PARITY_EN
            par_bit    <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (load) begin
                shreg   <= bus.fifo_rd_data;
                bit_cnt <= '0;
`ifdef FIFO_SER_PARITY_EN
                par_bit <= ^bus.fifo_rd_data;
`endif
            end else if (xfer) begin
                if (is_last) begin
                    bit_cnt <= '0;
                end else begin
                    bit_cnt <= bit_cnt + BC_W'(1);
                    shreg   <= MSB_FIRST ? (shreg << 1) : (shreg >> 1);
                end
            end
            if (xfer && is_last) begin
                words_sent <= words_sent + CNT_WIDTH'(1);
            end
        end
    end

endmodule
